// File: rtl/circulant_transpose_reader.sv
// circulant_transpose_reader
// Read-side sequencer for the circulant-skewed BRAM transpose buffer. Issues one
// diagonal read per original column, rotates the returned chunks back into row
// order and streams transposed rows through a 2-entry valid/ready FIFO.
// Optional build macro: CIRC_RD_RAW_MODE_EN adds a raw_mode input that bypasses
// the rotation (debug view of the stored diagonals).
module circulant_transpose_reader #(
    parameter int MATRIX_DIM = 4,
    parameter int MEM_WIDTH  = 8,
    parameter int ROW_WIDTH  = MATRIX_DIM * MEM_WIDTH,
    parameter int ADDR_LEN   = $clog2(MATRIX_DIM)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [ADDR_LEN-1:0]            base_mem,
`ifdef CIRC_RD_RAW_MODE_EN
    input  logic                           raw_mode,
`endif
    output logic                           busy,
    output logic                           done,
    output logic                           bram_ren,
    output logic [MATRIX_DIM*ADDR_LEN-1:0] bram_raddr,
    input  logic [ROW_WIDTH-1:0]           bram_rdata,
    output logic [ROW_WIDTH-1:0]           out_data,
    output logic [ADDR_LEN-1:0]            out_idx,
    output logic                           out_last,
    output logic                           out_valid,
    input  logic                           out_ready
);

    localparam logic [ADDR_LEN-1:0] LAST_IDX = ADDR_LEN'(MATRIX_DIM - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    typedef struct packed {
        logic [ROW_WIDTH-1:0] data;
        logic [ADDR_LEN-1:0]  idx;
        logic                 last;
    } beat_t;

    state_t              state, state_d;
    logic [ADDR_LEN-1:0] base_q;
    logic [ADDR_LEN-1:0] j_q;
    logic                in_flight;
    logic [ADDR_LEN-1:0] rd_shift;
    logic [ADDR_LEN-1:0] rd_idx;
    logic                rd_last;
    logic [ADDR_LEN-1:0] shift_next;
`ifdef CIRC_RD_RAW_MODE_EN
    logic                raw_q;
`endif

    beat_t               fifo_mem [2];
    logic                wr_ptr, rd_ptr;
    logic [1:0]          fifo_count;
    logic                push, pop, permit;
    logic [2:0]          occupancy;
    logic [ADDR_LEN-1:0] src_col [MATRIX_DIM];
    logic [ROW_WIDTH-1:0] rotated;

    // Rotation amount for the read being issued; raw mode pins it to zero.
`ifdef CIRC_RD_RAW_MODE_EN
    assign shift_next = raw_q ? '0 : ADDR_LEN'(base_q + j_q);
`else
    assign shift_next = ADDR_LEN'(base_q + j_q);
`endif

    // Credit check: reads in flight plus queued beats must leave room in the FIFO.
    assign pop       = out_valid & out_ready;
    assign push      = in_flight;
    assign occupancy = {2'b00, in_flight} + {1'b0, fifo_count} - {2'b00, pop};
    assign permit    = occupancy < 3'd2;
    assign bram_ren  = (state == ISSUE) && permit;
    assign busy      = (state != IDLE);

    // Diagonal read addresses: column m reads row (m - B - j) mod MATRIX_DIM.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        bram_raddr = '0;
        if (bram_ren) begin
            for (int m = 0; m < MATRIX_DIM; m++) begin
                bram_raddr[m*ADDR_LEN +: ADDR_LEN] = ADDR_LEN'(m) - base_q - j_q;
            end
        end
    end

    // Unscramble returned chunks: row r comes from BRAM column (r + s) mod MATRIX_DIM.
    always_comb begin
        rotated = '0;
        for (int r = 0; r < MATRIX_DIM; r++) begin
            src_col[r] = ADDR_LEN'(r) + rd_shift;
            rotated[r*MEM_WIDTH +: MEM_WIDTH] = bram_rdata[src_col[r]*MEM_WIDTH +: MEM_WIDTH];
        end
    end

    // Next-state logic and the end-of-tile done pulse.
    always_comb begin
        state_d = state;
        done    = 1'b0;
        case (state)
            IDLE:  if (start) state_d = ISSUE;
            ISSUE: if (bram_ren && (j_q == LAST_IDX)) state_d = DRAIN;
            DRAIN: begin
                if (!in_flight && (fifo_count == 2'd0)) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register, tile parameters and the read-in-flight pipeline stage.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state     <= IDLE;
            base_q    <= '0;
            j_q       <= '0;
            in_flight <= 1'b0;
            rd_shift  <= '0;
            rd_idx    <= '0;
            rd_last   <= 1'b0;
`ifdef CIRC_RD_RAW_MODE_EN
            raw_q     <= 1'b0;
`endif
        end else begin
            state     <= state_d;
            in_flight <= bram_ren;
            if (state == IDLE && start) begin
                base_q <= base_mem;
                j_q    <= '0;
`ifdef CIRC_RD_RAW_MODE_EN
                raw_q  <= raw_mode;
`endif
            end
            if (bram_ren) begin
                j_q      <= j_q + 1'b1;
                rd_shift <= shift_next;
                rd_idx   <= j_q;
                rd_last  <= (j_q == LAST_IDX);
            end
        end
    end

    // Two-entry output FIFO; push and pop on a full FIFO leaves occupancy unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the two storage entries are reset so the head (and hence
            // out_data/out_idx/out_last) reads zero out of reset.
            for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= '{data: rotated, idx: rd_idx, last: rd_last};
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign out_valid = (fifo_count != 2'd0);
    assign out_data  = fifo_mem[rd_ptr].data;
    assign out_idx   = fifo_mem[rd_ptr].idx;
    assign out_last  = fifo_mem[rd_ptr].last;

endmodule

// File: tb/tb_circulant_transpose_reader.sv
// Self-checking bench for circulant_transpose_reader (MATRIX_DIM=4, MEM_WIDTH=8).
// A behavioural 1-cycle BRAM holds element(r,c) = 16r+c at column (B+r+c) mod 4,
// address r. Build with CIRC_RD_RAW_MODE_EN to also cover the raw debug view.
module tb_circulant_transpose_reader;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int AL = 2;
    localparam int RW = N * W;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [AL-1:0]   base_mem = '0;
    logic            raw_mode = 1'b0;
    logic            busy, done, bram_ren, out_last, out_valid;
    logic            out_ready = 1'b0;
    logic [N*AL-1:0] bram_raddr;
    logic [RW-1:0]   bram_rdata = '0;
    logic [RW-1:0]   out_data;
    logic [AL-1:0]   out_idx;

    logic [W-1:0]    mem [N][N];
    int              n_checks = 0;
    int              n_pass = 0;

    circulant_transpose_reader #(.MATRIX_DIM(N), .MEM_WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_mem   (base_mem),
`ifdef CIRC_RD_RAW_MODE_EN
        .raw_mode   (raw_mode),
`endif
        .busy       (busy),
        .done       (done),
        .bram_ren   (bram_ren),
        .bram_raddr (bram_raddr),
        .bram_rdata (bram_rdata),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    // Behavioural BRAM bank: registered read, one cycle latency.
    always @(posedge clk) begin
        if (bram_ren) begin
            for (int m = 0; m < N; m++)
                bram_rdata[m*W +: W] <= mem[m][bram_raddr[m*AL +: AL]];
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        else n_pass++;
    endtask

    task automatic load_tile(input logic [AL-1:0] b);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                mem[(int'(b) + r + c) & (N - 1)][r] = W'(16 * r + c);
    endtask

    // Expected transposed row j; raw view shows column m holding row (m-B-j) mod N.
    function automatic logic [RW-1:0] exp_row(input int j, input logic [AL-1:0] b, input bit raw);
        logic [RW-1:0] row;
        int src;
        row = '0;
        for (int r = 0; r < N; r++) begin
            src = raw ? ((r - int'(b) - j) & (N - 1)) : r;
            row[r*W +: W] = W'(16 * src + j);
        end
        return row;
    endfunction

    // One full tile read with optional output stall and an ignored mid-run start.
    task automatic run_tile(input logic [AL-1:0] b, input bit raw, input int stall_len,
                            input int restart_cyc, input logic [7:0] exp_raddr0, input string tag);
        int cyc = 1;
        int beat = 0;
        int reads = 0;
        bit done_seen = 0;
        bit busy_ok = 1;
        load_tile(b);
        @(posedge clk); #1;
        start = 1'b1; base_mem = b; raw_mode = raw; out_ready = 1'b1;
        @(posedge clk); #1;
        while (!done_seen && cyc < 60) begin
            if (cyc == restart_cyc) begin start = 1'b1; base_mem = 2'd1; end
            else start = 1'b0;
            out_ready = (cyc < 3) || (cyc >= 3 + stall_len);
            #1;
            if (cyc == 1) begin
                check({tag, "_ren_c1"}, bram_ren, 1'b1);
                check({tag, "_raddr_c1"}, bram_raddr, exp_raddr0);
            end
            if (bram_ren) reads++;
            if (!busy) busy_ok = 0;
            if (out_valid && !out_ready)
                check({tag, "_stall_hold"}, out_data, exp_row(beat, b, raw));
            if (stall_len > 0 && cyc == 2 + stall_len)
                check({tag, "_reads_at_stall"}, reads, 2);
            if (out_valid && out_ready) begin
                check({tag, "_data"}, out_data, exp_row(beat, b, raw));
                check({tag, "_idx"}, out_idx, beat);
                check({tag, "_last"}, out_last, beat == N - 1);
                if (stall_len == 0) check({tag, "_beat_cycle"}, cyc, 3 + beat);
                beat++;
            end
            if (done) begin
                done_seen = 1;
                check({tag, "_beats_before_done"}, beat, N);
                if (stall_len == 0) check({tag, "_done_cycle"}, cyc, N + 3);
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        if (!done_seen) check({tag, "_timeout"}, 0, 1);
        #1;
        check({tag, "_busy_continuous"}, busy_ok, 1'b1);
        check({tag, "_busy_after"}, busy, 1'b0);
        check({tag, "_done_one_cycle"}, done, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_ren"}, bram_ren, 1'b0);
        check({tag, "_raddr"}, bram_raddr, '0);
        check({tag, "_valid"}, out_valid, 1'b0);
        check({tag, "_data"}, out_data, '0);
        check({tag, "_idx"}, out_idx, '0);
        check({tag, "_last"}, out_last, 1'b0);
    endtask

    initial begin
        bit quiet;
        repeat (2) @(posedge clk);
        #2;
        check_reset_outputs("por");
        rst_n = 1'b1;

        // B=0, continuous ready: beats in cycles 3..6, done in cycle 7.
        run_tile(2'd0, 1'b0, 0, -1, 8'hE4, "b0");
        // B=3: same transposed rows, cycle-1 addresses {0,3,2,1}.
        run_tile(2'd3, 1'b0, 0, -1, 8'h39, "b3");
        // Consumer stall for 5 cycles after first valid.
        run_tile(2'd0, 1'b0, 5, -1, 8'hE4, "stall");
        // Second start in cycle 2 with B=1 must be ignored.
        run_tile(2'd0, 1'b0, 0, 2, 8'hE4, "restart");

        // Reset asserted in cycle 4 aborts the read with no done.
        load_tile(2'd0);
        @(posedge clk); #1;
        start = 1'b1; base_mem = 2'd0; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        quiet = 1;
        repeat (6) begin
            @(posedge clk); #2;
            if (done || out_valid || busy) quiet = 0;
        end
        check("midrst_quiet", quiet, 1'b1);
        run_tile(2'd0, 1'b0, 0, -1, 8'hE4, "after_rst");

`ifdef CIRC_RD_RAW_MODE_EN
        run_tile(2'd0, 1'b1, 0, -1, 8'hE4, "raw");
        run_tile(2'd0, 1'b0, 0, -1, 8'hE4, "raw_off");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
